// File: rtl/io_stress_test_pkg.sv
// Shared mode encoding and LFSR step for the GLIP FIFO stress-test engine.
package io_stress_test_pkg;

    typedef enum logic [1:0] {
        MODE_CNT  = 2'd0,
        MODE_PRBS = 2'd1,
        MODE_LOOP = 2'd2,
        MODE_HALT = 2'd3
    } mode_e;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/io_stress_test_pattern_gen.sv
// Counter / PRBS word generator; used both for outgoing data and as the checker's expected value.
module io_stress_test_pattern_gen
    import io_stress_test_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter logic [31:0] SEED  = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] cnt;
    logic [31:0]      lfsr;

    // Both sequences step together so a mode switch never needs a catch-up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            lfsr <= SEED;
        end else if (load) begin
            cnt  <= '0;
            lfsr <= SEED;
        end else if (advance) begin
            cnt  <= cnt + WIDTH'(1);
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign data = (mode == 2'(MODE_PRBS)) ? lfsr[WIDTH-1:0] : cnt;

endmodule

// File: rtl/io_stress_test_mc.sv
// Multi-pattern GLIP FIFO stress engine: pattern generation, checking, loopback, stall and error injection.
module io_stress_test_mc
    import io_stress_test_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter logic [31:0] SEED         = 32'hACE1_2468,
    parameter int unsigned STALL_PERIOD = 64,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned IDLE_CYCLES  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] fifo_out_data,
    output logic             fifo_out_valid,
    input  logic             fifo_out_ready,
    input  logic [WIDTH-1:0] fifo_in_data,
    input  logic             fifo_in_valid,
    output logic             fifo_in_ready,
    input  logic             stall_flag,
    input  logic             error_flag,
    output logic             error,
    output logic             idle,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);

    localparam int unsigned SC_W     = $clog2(STALL_PERIOD);
    localparam int unsigned IDLE_W   = $clog2(IDLE_CYCLES + 1);
    localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(STALL_PERIOD - 1);
    localparam logic [SC_W-1:0]   SC_HALF  = SC_W'(STALL_PERIOD / 2);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

    mode_e             mode_q, mode_n;
    logic              started;
    logic [WIDTH-1:0]  lb0, lb1;
    logic [1:0]        lb_cnt, lb_cnt_pop, lb_cnt_n;
    logic [SC_W-1:0]   sc;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
    logic              mism_q;
    logic [WIDTH-1:0]  gen_data, chk_data;

    logic out_xfer, in_xfer, chg, stall, launch_ok, gen_launch, lb_launch;
    logic checking, chk_adv, lb_push, in_ready_n;

    // Handshake decode, mode latching and launch decisions for the coming edge
    always_comb begin
        out_xfer   = fifo_out_valid && fifo_out_ready;
        in_xfer    = fifo_in_valid && fifo_in_ready;
        mode_n     = (!fifo_out_valid || fifo_out_ready) ? mode_e'(mode) : mode_q;
        chg        = started && (mode_n != mode_q);
        stall      = stall_flag && (sc < SC_HALF);
        launch_ok  = !chg && !stall && (!fifo_out_valid || fifo_out_ready);
        gen_launch = launch_ok && (mode_n == MODE_CNT || mode_n == MODE_PRBS);
        lb_launch  = launch_ok && (mode_n == MODE_LOOP) && (lb_cnt != 2'd0);
        checking   = (mode_q == MODE_CNT) || (mode_q == MODE_PRBS);
        chk_adv    = in_xfer && checking;
        lb_push    = in_xfer && (mode_q == MODE_LOOP) && !chg;
        lb_cnt_pop = lb_cnt - 2'(lb_launch);
        lb_cnt_n   = chg ? 2'd0 : lb_cnt_pop + 2'(lb_push);
        in_ready_n = !stall && (mode_n != MODE_HALT)
                     && !((mode_n == MODE_LOOP) && (lb_cnt_n == 2'd2));
        idle_cnt_n = idle_cnt;
        if (in_xfer || out_xfer)
            idle_cnt_n = '0;
        else if (idle_cnt != IDLE_MAX)
            idle_cnt_n = idle_cnt + IDLE_W'(1);
    end

    io_stress_test_pattern_gen #(.WIDTH(WIDTH), .SEED(SEED)) u_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (chg),
        .advance (gen_launch),
        .mode    (mode_n),
        .data    (gen_data)
    );

    io_stress_test_pattern_gen #(.WIDTH(WIDTH), .SEED(SEED)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .load    (chg),
        .advance (chk_adv),
        .mode    (mode_q),
        .data    (chk_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q         <= MODE_CNT;
            started        <= 1'b0;
            fifo_out_valid <= 1'b0;
            fifo_out_data  <= '0;
            fifo_in_ready  <= 1'b0;
            lb0            <= '0;
            lb1            <= '0;
            lb_cnt         <= 2'd0;
            sc             <= '0;
            idle_cnt       <= '0;
            idle           <= 1'b0;
            mism_q         <= 1'b0;
            error          <= 1'b0;
            err_count      <= '0;
            word_count     <= '0;
        end else begin
            started       <= 1'b1;
            mode_q        <= mode_n;
            fifo_in_ready <= in_ready_n;
            lb_cnt        <= lb_cnt_n;
            sc            <= (sc == SC_LAST) ? '0 : sc + SC_W'(1);
            idle_cnt      <= idle_cnt_n;
            idle          <= (idle_cnt_n == IDLE_MAX);

            if (gen_launch) begin
                fifo_out_valid <= 1'b1;
                fifo_out_data  <= gen_data ^ WIDTH'(error_flag);
            end else if (lb_launch) begin
                fifo_out_valid <= 1'b1;
                fifo_out_data  <= lb0;
            end else if (out_xfer) begin
                fifo_out_valid <= 1'b0;
            end

            // Pop shifts the head; a push into the freed slot overrides it
            if (lb_launch)
                lb0 <= lb1;
            if (lb_push) begin
                if (lb_cnt_pop == 2'd0)
                    lb0 <= fifo_in_data;
                else
                    lb1 <= fifo_in_data;
            end

            // Mismatch is registered first, so the counters lag the transfer by one edge
            mism_q <= chk_adv && (fifo_in_data != chk_data);
            if (mism_q) begin
                error <= 1'b1;
                if (err_count != '1)
                    err_count <= err_count + CNT_W'(1);
            end

            if (chk_adv || ((mode_q == MODE_LOOP) && out_xfer))
                word_count <= word_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_io_stress_test_mc.sv
// Randomised self-checking bench for io_stress_test_mc against a sequence-level reference model.
module tb_io_stress_test_mc;

    localparam int unsigned WIDTH        = 16;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned STALL_PERIOD = 8;
    localparam int unsigned IDLE_CYCLES  = 20;
    localparam logic [31:0] SEED         = 32'hACE1_2468;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       mode = 2'd0;
    logic [WIDTH-1:0] fifo_out_data;
    logic             fifo_out_valid;
    logic             fifo_out_ready = 1'b0;
    logic [WIDTH-1:0] fifo_in_data = '0;
    logic             fifo_in_valid = 1'b0;
    logic             fifo_in_ready;
    logic             stall_flag = 1'b0;
    logic             error_flag = 1'b0;
    logic             error;
    logic             idle;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;

    int checks = 0;
    int errors = 0;

    io_stress_test_mc #(
        .WIDTH(WIDTH), .SEED(SEED), .STALL_PERIOD(STALL_PERIOD),
        .CNT_W(CNT_W), .IDLE_CYCLES(IDLE_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .fifo_out_data(fifo_out_data), .fifo_out_valid(fifo_out_valid),
        .fifo_out_ready(fifo_out_ready), .fifo_in_data(fifo_in_data),
        .fifo_in_valid(fifo_in_valid), .fifo_in_ready(fifo_in_ready),
        .stall_flag(stall_flag), .error_flag(error_flag), .error(error),
        .idle(idle), .err_count(err_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Record every outgoing transfer and the edge it happened on
    logic [WIDTH-1:0] out_q[$];
    int               out_edge[$];
    int               edge_n = 0;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (!rst && fifo_out_valid && fifo_out_ready) begin
            out_q.push_back(fifo_out_data);
            out_edge.push_back(edge_n);
        end
    end

    // One step of x^32+x^22+x^2+x+1 in Galois form: shift toward bit 0, fold the dropped bit back in
    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
        return s;
    endfunction

    // n-th word of the counter (m=0) or PRBS (m=1) sequence
    function automatic logic [WIDTH-1:0] ref_word(input int m, input int n);
        logic [31:0] s;
        s = SEED;
        if (m == 0) return WIDTH'(n);
        for (int i = 0; i < n; i++) s = ref_lfsr(s);
        return s[WIDTH-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        rst = 1'b1;
        fifo_out_ready = 1'b0;
        fifo_in_valid  = 1'b0;
        fifo_in_data   = '0;
        stall_flag     = 1'b0;
        error_flag     = 1'b0;
        mode           = m;
        tick();
        tick();
        out_q.delete();
        out_edge.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 7;
        if (fifo_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", fifo_out_valid); end
        if (fifo_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", fifo_in_ready); end
        if (fifo_out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", fifo_out_data); end
        if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error); end
        if (err_count !== '0) begin errors++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
        if (word_count !== '0) begin errors++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
        if (idle !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b want 0", idle); end
    endtask

    task automatic test_counter();
        int hi = 0;
        int cyc = 0;
        logic xf;
        do_reset(2'd0);
        fifo_out_ready = 1'b1;
        while ((out_q.size() < 1024 || hi < 1024) && cyc < 4000) begin
            fifo_in_valid = (hi < 1024);
            fifo_in_data  = ref_word(0, hi);
            xf = fifo_in_valid && fifo_in_ready;
            tick();
            cyc++;
            if (xf) hi++;
            if (cyc == 1) begin
                checks++;
                if (fifo_out_valid !== 1'b1 || fifo_out_data !== ref_word(0, 0)) begin
                    errors++; $display("FAIL cnt_first_word: got v=%b d=%h want v=1 d=%h", fifo_out_valid, fifo_out_data, ref_word(0, 0));
                end
            end
        end
        fifo_in_valid = 1'b0;
        fifo_out_ready = 1'b0;
        checks++;
        if (out_q.size() < 1024 || hi < 1024) begin
            errors++; $display("FAIL cnt_timeout: got out=%0d in=%0d want 1024 each", out_q.size(), hi);
        end else begin
            for (int i = 0; i < 1024; i++) begin
                checks++;
                if (out_q[i] !== ref_word(0, i)) begin errors++; $display("FAIL cnt_word%0d: got %h want %h", i, out_q[i], ref_word(0, i)); end
            end
            checks++;
            if (out_edge[1023] - out_edge[0] != 1023) begin
                errors++; $display("FAIL cnt_back_to_back: got span %0d want 1023", out_edge[1023] - out_edge[0]);
            end
        end
        tick();
        tick();
        checks += 2;
        if (err_count !== '0 || error !== 1'b0) begin errors++; $display("FAIL cnt_no_errors: got cnt=%0d err=%b want 0/0", err_count, error); end
        if (word_count !== CNT_W'(1024)) begin errors++; $display("FAIL cnt_word_count: got %0d want %0d", word_count, CNT_W'(1024)); end
    endtask

    task automatic test_prbs();
        int hi = 0;
        int cyc = 0;
        logic xf;
        logic chk_next = 1'b0;
        logic [31:0] seed_v = SEED;
        do_reset(2'd1);
        fifo_out_ready = 1'b1;
        while ((out_q.size() < 40 || hi < 40) && cyc < 500) begin
            fifo_in_valid = (hi < 40);
            fifo_in_data  = ref_word(1, hi) ^ ((hi == 5) ? WIDTH'(1) : WIDTH'(0));
            xf = fifo_in_valid && fifo_in_ready;
            tick();
            cyc++;
            if (chk_next) begin
                chk_next = 1'b0;
                checks++;
                if (err_count !== CNT_W'(1) || error !== 1'b1) begin
                    errors++; $display("FAIL prbs_err_latency_late: got cnt=%0d err=%b want 1/1", err_count, error);
                end
            end
            if (xf) begin
                if (hi == 5) begin
                    checks++;
                    if (err_count !== '0) begin errors++; $display("FAIL prbs_err_latency_early: got %0d want 0", err_count); end
                    chk_next = 1'b1;
                end
                hi++;
            end
        end
        fifo_in_valid = 1'b0;
        fifo_out_ready = 1'b0;
        checks++;
        if (out_q.size() < 40) begin
            errors++; $display("FAIL prbs_timeout: got %0d words want 40", out_q.size());
        end else begin
            checks++;
            if (out_q[0] !== seed_v[WIDTH-1:0]) begin errors++; $display("FAIL prbs_first: got %h want %h", out_q[0], seed_v[WIDTH-1:0]); end
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (out_q[i] !== ref_word(1, i)) begin errors++; $display("FAIL prbs_word%0d: got %h want %h", i, out_q[i], ref_word(1, i)); end
            end
        end
        tick();
        tick();
        checks += 2;
        if (err_count !== CNT_W'(1) || error !== 1'b1) begin errors++; $display("FAIL prbs_err_final: got cnt=%0d err=%b want 1/1", err_count, error); end
        if (word_count !== CNT_W'(40)) begin errors++; $display("FAIL prbs_word_count: got %0d want %0d", word_count, CNT_W'(40)); end
    endtask

    task automatic test_error_inject();
        logic [WIDTH-1:0] exp;
        do_reset(2'd0);
        fifo_out_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            error_flag = (k == 5);
            tick();
        end
        error_flag = 1'b0;
        fifo_out_ready = 1'b0;
        checks++;
        if (out_q.size() < 10) begin
            errors++; $display("FAIL inj_count: got %0d want >=10", out_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                exp = ref_word(0, i) ^ ((i == 4) ? WIDTH'(1) : WIDTH'(0));
                checks++;
                if (out_q[i] !== exp) begin errors++; $display("FAIL inj_word%0d: got %h want %h", i, out_q[i], exp); end
            end
        end
    endtask

    task automatic test_stall();
        int lows[8];
        logic pv, pr;
        logic [WIDTH-1:0] pd;
        do_reset(2'd0);
        stall_flag = 1'b1;
        foreach (lows[w]) lows[w] = 0;
        for (int c = 0; c < 64; c++) begin
            fifo_out_ready = 1'($urandom_range(0, 1));
            pv = fifo_out_valid;
            pd = fifo_out_data;
            pr = fifo_out_ready;
            tick();
            if (!fifo_in_ready) lows[c / 8]++;
            if (pv && !pr) begin
                checks++;
                if (fifo_out_valid !== 1'b1 || fifo_out_data !== pd) begin
                    errors++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h", fifo_out_valid, fifo_out_data, pd);
                end
            end
        end
        stall_flag = 1'b0;
        fifo_out_ready = 1'b0;
        foreach (lows[w]) begin
            checks++;
            if (lows[w] != STALL_PERIOD / 2) begin errors++; $display("FAIL stall_window%0d: got %0d low want %0d", w, lows[w], STALL_PERIOD / 2); end
        end
        checks++;
        if (out_q.size() == 0) begin errors++; $display("FAIL stall_progress: got 0 words want >0"); end
        for (int i = 0; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== ref_word(0, i)) begin errors++; $display("FAIL stall_word%0d: got %h want %h", i, out_q[i], ref_word(0, i)); end
        end
    endtask

    task automatic test_mode_change();
        int cyc = 0;
        do_reset(2'd0);
        fifo_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        mode = 2'd1;
        while (out_q.size() < 10 && cyc < 50) begin
            tick();
            cyc++;
        end
        fifo_out_ready = 1'b0;
        checks++;
        if (out_q.size() < 10) begin
            errors++; $display("FAIL mchg_timeout: got %0d words want 10", out_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (out_q[i] !== ((i < 5) ? ref_word(0, i) : ref_word(1, i - 5))) begin
                    errors++; $display("FAIL mchg_word%0d: got %h want %h", i, out_q[i], (i < 5) ? ref_word(0, i) : ref_word(1, i - 5));
                end
            end
        end
    endtask

    task automatic test_loopback();
        logic [WIDTH-1:0] words[37];
        int hi = 0;
        int cyc = 0;
        int lat = 0;
        logic xf;
        foreach (words[i]) words[i] = WIDTH'($urandom);
        do_reset(2'd2);
        while ((out_q.size() < 37 || hi < 37) && cyc < 2000) begin
            fifo_in_valid  = (hi < 37);
            fifo_in_data   = (hi < 37) ? words[hi] : '0;
            fifo_out_ready = 1'($urandom_range(0, 1));
            xf = fifo_in_valid && fifo_in_ready;
            tick();
            cyc++;
            if (lat == 1) begin
                lat = 2;
                checks++;
                if (fifo_out_valid !== 1'b1 || fifo_out_data !== words[0]) begin
                    errors++; $display("FAIL lb_latency_late: got v=%b d=%h want v=1 d=%h", fifo_out_valid, fifo_out_data, words[0]);
                end
            end
            if (xf) begin
                if (hi == 0) begin
                    lat = 1;
                    checks++;
                    if (fifo_out_valid !== 1'b0) begin errors++; $display("FAIL lb_latency_early: got v=%b want 0", fifo_out_valid); end
                end
                hi++;
            end
        end
        fifo_in_valid = 1'b0;
        fifo_out_ready = 1'b0;
        tick();
        checks++;
        if (out_q.size() != 37) begin
            errors++; $display("FAIL lb_count: got %0d words want 37", out_q.size());
        end else begin
            foreach (words[i]) begin
                checks++;
                if (out_q[i] !== words[i]) begin errors++; $display("FAIL lb_word%0d: got %h want %h", i, out_q[i], words[i]); end
            end
        end
        checks += 2;
        if (word_count !== CNT_W'(37)) begin errors++; $display("FAIL lb_word_count: got %0d want %0d", word_count, CNT_W'(37)); end
        if (error !== 1'b0) begin errors++; $display("FAIL lb_error: got %b want 0", error); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] words[16];
        int hi = 0;
        int cyc = 0;
        logic xf;
        foreach (words[i]) words[i] = WIDTH'($urandom);
        do_reset(2'd2);
        fifo_out_ready = 1'b1;
        while (out_q.size() < 16 && cyc < 200) begin
            fifo_in_valid = (hi < 16);
            fifo_in_data  = (hi < 16) ? words[hi] : '0;
            xf = fifo_in_valid && fifo_in_ready;
            tick();
            cyc++;
            if (xf) hi++;
        end
        fifo_in_valid = 1'b0;
        fifo_out_ready = 1'b0;
        checks++;
        if (out_q.size() < 16) begin
            errors++; $display("FAIL b2b_count: got %0d want 16", out_q.size());
        end else begin
            checks++;
            if (out_edge[15] - out_edge[0] != 15) begin errors++; $display("FAIL b2b_span: got %0d want 15", out_edge[15] - out_edge[0]); end
            foreach (words[i]) begin
                checks++;
                if (out_q[i] !== words[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, out_q[i], words[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2'd0);
        fifo_out_ready = 1'b1;
        fifo_in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            fifo_in_data = WIDTH'($urandom) | WIDTH'(16'h8000);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (fifo_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", fifo_out_valid); end
        if (fifo_in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b want 0", fifo_in_ready); end
        if (err_count !== '0) begin errors++; $display("FAIL mid_err_count: got %0d want 0", err_count); end
        if (word_count !== '0) begin errors++; $display("FAIL mid_word_count: got %0d want 0", word_count); end
        if (error !== 1'b0) begin errors++; $display("FAIL mid_error: got %b want 0", error); end
        fifo_in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (fifo_out_valid !== 1'b1 || fifo_out_data !== ref_word(0, 0)) begin
            errors++; $display("FAIL mid_restart: got v=%b d=%h want v=1 d=%h", fifo_out_valid, fifo_out_data, ref_word(0, 0));
        end
        fifo_out_ready = 1'b0;
    endtask

    task automatic test_saturation_idle();
        int hi = 0;
        int cyc = 0;
        logic xf;
        do_reset(2'd0);
        fifo_out_ready = 1'b1;
        while (hi < 20 && cyc < 200) begin
            fifo_in_valid = 1'b1;
            fifo_in_data  = ref_word(0, hi) ^ WIDTH'(16'h8000);
            xf = fifo_in_ready;
            tick();
            cyc++;
            if (xf) hi++;
        end
        fifo_in_valid  = 1'b0;
        fifo_out_ready = 1'b0;
        checks++;
        if (hi < 20) begin errors++; $display("FAIL sat_timeout: got %0d words want 20", hi); end
        for (int k = 0; k <= IDLE_CYCLES + 2; k++) begin
            if (k > 0) tick();
            checks++;
            if (idle !== ((k >= IDLE_CYCLES) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL idle_k%0d: got %b want %b", k, idle, (k >= IDLE_CYCLES));
            end
        end
        checks += 2;
        if (err_count !== CNT_W'(15)) begin errors++; $display("FAIL sat_err_count: got %0d want 15", err_count); end
        if (error !== 1'b1) begin errors++; $display("FAIL sat_error: got %b want 1", error); end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_prbs();
        test_error_inject();
        test_stall();
        test_mode_change();
        test_loopback();
        test_back_to_back();
        test_reset_mid();
        test_saturation_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
